seven_seg_scan_decoder: RTL

Recovers hex digit values from the segment and anode lines of a time-multiplexed seven-segment display, the inverse of the team's BCD-to-seven-segment encoding. It sits on the board-side display bus as a monitor: it samples anodes and segments, debounces each digit slot, decodes the pattern back to a nibble and publishes a complete multi-digit word once every digit has been captured. Illegal patterns and malformed anode selects are flagged.

---
 rtl/seven_seg_scan_decoder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder
// Monitors a multiplexed seven-segment display bus and rebuilds the hex word
// being shown. Each {an, sevenSeg} sample must stay identical for
// STABLE_CYCLES edges before it is accepted. An accepted one-hot-low anode
// writes its decoded nibble into a shadow word. Once every digit has been seen,
// the shadow word is published together with a frame-level error flag.
module seven_seg_scan_decoder #(
  parameter int N_DIGITS      = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_DIGITS-1:0]   an,
  input  logic [6:0]            sevenSeg,
  output logic [4*N_DIGITS-1:0] value,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  anode_err
);

  localparam int SW = N_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  // Inverse of the team's segment encoder; bit 4 flags an unknown pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h7E:   res = {1'b0, 4'h0};
      7'h30:   res = {1'b0, 4'h1};
      7'h6D:   res = {1'b0, 4'h2};
      7'h79:   res = {1'b0, 4'h3};
      7'h33:   res = {1'b0, 4'h4};
      7'h5B:   res = {1'b0, 4'h5};
      7'h1F:   res = {1'b0, 4'h6};
      7'h70:   res = {1'b0, 4'h7};
      7'h7F:   res = {1'b0, 4'h8};
      7'h73:   res = {1'b0, 4'h9};
      7'h0D:   res = {1'b0, 4'hA};
      7'h19:   res = {1'b0, 4'hB};
      7'h23:   res = {1'b0, 4'hC};
      7'h4B:   res = {1'b0, 4'hD};
      7'h0F:   res = {1'b0, 4'hE};
      7'h00:   res = {1'b0, 4'hF};
      default: res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

  logic [SW-1:0]         r_sample;
  logic [CW-1:0]         r_cnt;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic [N_DIGITS-1:0]   r_seen;
  logic [N_DIGITS-1:0]   r_err;

  logic [SW-1:0]         w_sample;
  logic                  w_same;
  logic                  w_capture;
  logic [N_DIGITS-1:0]   w_low;
  logic                  w_blank;
  logic                  w_onehot;
  logic [3:0]            w_nibble;
  logic                  w_illegal;
  logic [4*N_DIGITS-1:0] w_shadow_next;
  logic [N_DIGITS-1:0]   w_seen_next;
  logic [N_DIGITS-1:0]   w_err_next;
  logic                  w_write;
  logic                  w_anode_bad;
  logic                  w_complete;

  assign w_sample = {an, sevenSeg};
  assign w_same   = (w_sample == r_sample);
  // A new value is first sampled at cnt 0. Reaching cnt == STABLE_CYCLES-2 on a
  // matching edge means this edge is the STABLE_CYCLES-th identical sample.
  // Saturation at STABLE_CYCLES keeps this from firing twice per stable period.
  assign w_capture = w_same && (r_cnt == CW'(STABLE_CYCLES - 2));

  assign w_low    = ~an;
  assign w_blank  = &an;
  assign w_onehot = (w_low != '0) &&
                    ((w_low & (w_low - N_DIGITS'(1))) == '0);

  assign {w_illegal, w_nibble} = seg_decode(sevenSeg);

  // Sample history and the saturating stability counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample <= '0;
      r_cnt    <= '0;
    end else begin
      r_sample <= w_sample;
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != CW'(STABLE_CYCLES))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // Next shadow/seen/err contents for a capture, plus the frame-completion test
  always_comb begin
    w_shadow_next = r_shadow;
    w_seen_next   = r_seen;
    w_err_next    = r_err;
    w_write       = 1'b0;
    w_anode_bad   = 1'b0;
    if (w_capture && !w_blank) begin
      if (w_onehot) begin
        w_write = 1'b1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
          if (w_low[i]) begin
            w_shadow_next[4*i +: 4] = w_nibble;
            w_seen_next[i]          = 1'b1;
            w_err_next[i]           = w_illegal;
          end
        end
      end else begin
        w_anode_bad = 1'b1;
      end
    end
    w_complete = w_write && (&w_seen_next);
  end

  // Shadow bookkeeping and publication of completed frames
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow    <= '0;
      r_seen      <= '0;
      r_err       <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      r_shadow    <= w_shadow_next;
      anode_err   <= w_anode_bad;
      frame_valid <= w_complete;
      frame_err   <= w_complete && (|w_err_next);
      if (w_complete) begin
        value  <= w_shadow_next;
        r_seen <= '0;
        r_err  <= '0;
      end else begin
        r_seen <= w_seen_next;
        r_err  <= w_err_next;
      end
    end
  end

endmodule
